// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the fir filter and its coefficient loader.
// Exports loader_state_e plus coefficient-count and counter-width functions.
package fir_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    WAIT,
    STREAM,
    GUARD
  } loader_state_e;

  function automatic int ncoeffs(input int ntaps);
    return (ntaps + 1) / 2;
  endfunction

  function automatic int stream_cnt_w(input int nc, input int dw);
    return (nc * dw > 1) ? $clog2(nc * dw) : 1;
  endfunction

  function automatic int idx_w(input int nc);
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction

endpackage

// File: rtl/fir_coeff_loader_piso_shifter.sv
// piso_shifter: parallel-load, serial-out register, MSB first; load wins over shift.
// Ports: clk, rst (sync, active-high), load, shift, din[Width], dout (registered MSB).
module piso_shifter #(
  parameter int Width = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [Width-1:0] din,
  output logic             dout
);

  logic [Width-1:0] sr_q;
  logic [Width-1:0] sr_d;

  // Zeros shift in, so once every bit has left the
  // register the serial output idles at 0 by itself.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = {sr_q[Width-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[Width-1];

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: buffers NCoeffs coefficients via valid/ready, streams them
// bit-serially into the idle fir, and gates fir start around the load.
// Ports: clk, rst, wr_valid/wr_ready/wr_data, start_in, fir_done, start_out,
// coeff_load_out, coeff_out, load_done, overrun (FIR_COEFF_LOADER_OVERRUN_EN).
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int DataWidth = 12,
  parameter int NTaps     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 start_in,
  input  logic                 fir_done,
  output logic                 start_out,
  output logic                 coeff_load_out,
  output logic                 coeff_out,
`ifdef FIR_COEFF_LOADER_OVERRUN_EN
  output logic                 overrun,
`endif
  output logic                 load_done
);

  localparam int NCoeffs = ncoeffs(NTaps);
  localparam int Bits    = NCoeffs * DataWidth;
  localparam int CntW    = stream_cnt_w(NCoeffs, DataWidth);
  localparam int IdxW    = idx_w(NCoeffs);

  localparam logic [CntW-1:0] LastBit = CntW'(Bits - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCoeffs - 1);

  if (NTaps % 2 == 0) begin : g_bad_ntaps
    $fatal(1, "fir_coeff_loader: NTaps must be odd");
  end

  loader_state_e state_q, state_d;

  logic [DataWidth-1:0] coef_q [NCoeffs];
  logic [DataWidth-1:0] coef_d [NCoeffs];

  logic [IdxW-1:0] wcnt_q, wcnt_d;
  logic [CntW-1:0] scnt_q, scnt_d;
  logic            busy_q, busy_d;
  logic            pending_q, pending_d;
  logic            cload_q, cload_d;

  logic            start_c;
  logic            ready_c;
  logic            piso_load;
  logic            piso_shift;
  logic [Bits-1:0] flat;

  // coef[NCoeffs-1] sits at the top so it leaves first.
  always_comb begin
    flat = '0;
    for (int i = 0; i < NCoeffs; i++) begin
      flat[i*DataWidth +: DataWidth] = coef_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    scnt_d     = scnt_q;
    pending_d  = pending_q;
    cload_d    = 1'b0;
    start_c    = 1'b0;
    ready_c    = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    for (int i = 0; i < NCoeffs; i++) begin
      coef_d[i] = coef_q[i];
    end

    unique case (state_q)
      COLLECT: begin
        ready_c = 1'b1;
        // A held start goes out now; a new strobe in
        // the same cycle merges into that one pulse.
        start_c   = start_in | pending_q;
        pending_d = 1'b0;
        if (wr_valid) begin
          coef_d[wcnt_q] = wr_data;
          if (wcnt_q == LastIdx) begin
            wcnt_d  = '0;
            state_d = WAIT;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        start_c   = start_in | pending_q;
        pending_d = 1'b0;
        if (!busy_q && !start_in) begin
          state_d   = STREAM;
          piso_load = 1'b1;
          cload_d   = 1'b1;
          scnt_d    = '0;
        end
      end
      STREAM: begin
        piso_shift = 1'b1;
        cload_d    = 1'b1;
        if (start_in) begin
          pending_d = 1'b1;
        end
        if (scnt_q == LastBit) begin
          state_d = GUARD;
          cload_d = 1'b0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      GUARD: begin
        // Filter still shifts samples this cycle,
        // so starts are held back one more cycle.
        if (start_in) begin
          pending_d = 1'b1;
        end
        state_d = COLLECT;
      end
    endcase

    // start_out wins over a same-cycle done.
    busy_d = busy_q;
    if (start_c) begin
      busy_d = 1'b1;
    end else if (fir_done) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      wcnt_q    <= '0;
      scnt_q    <= '0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      cload_q   <= 1'b0;
      for (int i = 0; i < NCoeffs; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      scnt_q    <= scnt_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      cload_q   <= cload_d;
      for (int i = 0; i < NCoeffs; i++) begin
        coef_q[i] <= coef_d[i];
      end
    end
  end

  piso_shifter #(
    .Width (Bits)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .shift (piso_shift),
    .din   (flat),
    .dout  (coeff_out)
  );

`ifdef FIR_COEFF_LOADER_OVERRUN_EN
  logic overrun_q, overrun_d;

  // A strobe meeting an already-held start is lost
  // in every state.
  always_comb begin
    overrun_d = overrun_q | (start_in & pending_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

  assign wr_ready       = ready_c & ~rst;
  assign start_out      = start_c & ~rst;
  assign coeff_load_out = cload_q;
  assign load_done      = (state_q == GUARD);

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader (NTaps=9, DataWidth=12, 60-bit loads).
// Includes a shift-register fir coefficient model fed by coeff_load_out/coeff_out.
module tb_fir_coeff_loader;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_data;
  logic        start_in;
  logic        fir_done;
  logic        start_out;
  logic        coeff_load_out;
  logic        coeff_out;
  logic        load_done;
`ifdef FIR_COEFF_LOADER_OVERRUN_EN
  logic        overrun;
`endif

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  logic [59:0] fir_sr;

  fir_coeff_loader #(
    .DataWidth (12),
    .NTaps     (9)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .start_in       (start_in),
    .fir_done       (fir_done),
    .start_out      (start_out),
    .coeff_load_out (coeff_load_out),
    .coeff_out      (coeff_out),
`ifdef FIR_COEFF_LOADER_OVERRUN_EN
    .overrun        (overrun),
`endif
    .load_done      (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fir coefficient chain: first bit ends in slot 4 bit 11.
  always @(posedge clk) begin
    if (rst) fir_sr <= '0;
    else if (coeff_load_out) fir_sr <= {fir_sr[58:0], coeff_out};
  end

  always @(posedge clk) begin
    if (start_out) n_start <= n_start + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // slot0 (low 12 bits) is written first.
  task automatic write_set(input logic [59:0] s);
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = s[i*12 +: 12];
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(output int hi, output logic found);
    hi = 0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (load_done) begin
        found = 1'b1;
        break;
      end
      if (coeff_load_out) hi++;
      tick();
    end
  endtask

  // Sits on stream bit 0; pulses start_in at bits a and b.
  task automatic stream_pulses(input int a, input int b,
                               output logic saw_start);
    saw_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      start_in = (i == a) || (i == b);
      #1;
      if (start_out) saw_start = 1'b1;
      tick();
    end
    start_in = 1'b0;
  endtask

  logic [59:0] set;
  int          hi;
  logic        found;
  logic        flag;
  int          n0;
  logic [7:0]  rdy;
  int          acc;

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = '0;
    start_in = 1'b0;
    fir_done = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_start_out", start_out, 0);
    chk("rst_coeff_load", coeff_load_out, 0);
    rst = 1'b0;
    #1;
    chk("idle_wr_ready", wr_ready, 1);
    chk("idle_coeff_out", coeff_out, 0);
    chk("idle_load_done", load_done, 0);
`ifdef FIR_COEFF_LOADER_OVERRUN_EN
    chk("idle_overrun", overrun, 0);
`endif

    // Normal load
    set = {12'h040, 12'h080, 12'h100, 12'h200, 12'h400};
    write_set(set);
    #1;
    chk("n_wait_ready", wr_ready, 0);
    chk("n_wait_cload", coeff_load_out, 0);
    tick();
    chk("n_lat2_cload", coeff_load_out, 1);
    wait_done(hi, found);
    chk("n_found", found, 1);
    chk("n_hi_cycles", hi, 60);
    chk("n_first12", fir_sr[59:48], 12'b000001000000);
    chk("n_last12", fir_sr[11:0], 12'b010000000000);
    chk("n_slot0", fir_sr[11:0], 12'h400);
    chk("n_slot4", fir_sr[59:48], 12'h040);
    chk("n_guard_cload", coeff_load_out, 0);
    chk("n_guard_cout", coeff_out, 0);
    tick();
    #1;
    chk("n_ready_back", wr_ready, 1);
    chk("n_done_pulse", load_done, 0);

    // Busy hold
    start_in = 1'b1;
    #1;
    chk("b_start_comb", start_out, 1);
    tick();
    start_in = 1'b0;
    set = {12'h005, 12'h004, 12'h003, 12'h002, 12'h001};
    write_set(set);
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (coeff_load_out || wr_ready) flag = 1'b1;
      tick();
    end
    chk("b_held_wait", flag, 0);
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    #1;
    chk("b_done_plus1", coeff_load_out, 0);
    tick();
    chk("b_done_plus2", coeff_load_out, 1);
    wait_done(hi, found);
    chk("b_hi_cycles", hi, 60);
    chk("b_coeffs", fir_sr, set);
    tick();

    // Start during stream
    set = {12'h7FF, 12'h800, 12'hABC, 12'h123, 12'hFFF};
    write_set(set);
    tick();
    n0 = n_start;
    stream_pulses(10, -1, flag);
    chk("s_no_start_strm", flag, 0);
    #1;
    chk("s_guard_done", load_done, 1);
    chk("s_guard_start", start_out, 0);
    tick();
    chk("s_first_collect", start_out, 1);
    tick();
    chk("s_after_start", start_out, 0);
    chk("s_one_pulse", n_start - n0, 1);
    chk("s_coeffs", fir_sr, set);
`ifdef FIR_COEFF_LOADER_OVERRUN_EN
    chk("s_no_overrun", overrun, 0);
`endif
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;

    // Overrun
    set = {12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
    write_set(set);
    tick();
    n0 = n_start;
    stream_pulses(5, 20, flag);
    chk("o_no_start_strm", flag, 0);
    #1;
    chk("o_guard_start", start_out, 0);
`ifdef FIR_COEFF_LOADER_OVERRUN_EN
    chk("o_overrun", overrun, 1);
`endif
    tick();
    chk("o_collect_start", start_out, 1);
    tick();
    tick();
    chk("o_one_pulse", n_start - n0, 1);
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;

    // Backpressure
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      wr_valid = 1'b1;
      wr_data = 12'h011 + 12'(k);
      #1;
      rdy[k] = wr_ready;
      if (wr_ready) acc++;
      tick();
    end
    wr_valid = 1'b0;
    chk("p_ready_map", rdy, 8'h1F);
    chk("p_accepted", acc, 5);
    wait_done(hi, found);
    chk("p_hi_rest", hi, 58);
    chk("p_coeffs", fir_sr,
        {12'h015, 12'h014, 12'h013, 12'h012, 12'h011});
    tick();

    // Reset mid-stream
    set = {12'h0F0, 12'h00F, 12'hF00, 12'h5A5, 12'hA5A};
    write_set(set);
    tick();
    for (int i = 0; i < 30; i++) tick();
    #1;
    chk("r_streaming", coeff_load_out, 1);
    rst = 1'b1;
    start_in = 1'b1;
    tick();
    #1;
    chk("r_cload", coeff_load_out, 0);
    chk("r_cout", coeff_out, 0);
    chk("r_done", load_done, 0);
    chk("r_start", start_out, 0);
    chk("r_ready_low", wr_ready, 0);
    rst = 1'b0;
    start_in = 1'b0;
    #1;
    chk("r_ready_high", wr_ready, 1);
    set = {12'h321, 12'h654, 12'h987, 12'hCBA, 12'hFED};
    write_set(set);
    tick();
    chk("r_lat2", coeff_load_out, 1);
    wait_done(hi, found);
    chk("r_found", found, 1);
    chk("r_hi_cycles", hi, 60);
    chk("r_coeffs", fir_sr, set);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient front-end for the `fir` filter. Accepts one signed coefficient per valid/ready handshake, buffers a full set of `NCoeffs`, and streams it bit-serially into the filter's `coeff_load_in`/`coeff_in` pins. It only does this while the filter is idle. It also gates the filter's `start` so that a sample strobe never collides with a coefficient load.

## Interface
Parameters:
- `DataWidth`, 12, coefficient width, SFix<1,DataWidth-1>
- `NTaps`, 9, filter taps, must be odd (elaboration `$fatal` otherwise)
- `NCoeffs`, localparam = (NTaps+1)/2

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `wr_valid`  in  1  coefficient write valid
- `wr_ready`  out  1  loader accepts a coefficient this cycle
- `wr_data`  in  DataWidth  coefficient, signed
- `start_in`  in  1  sample strobe from the sample-rate source
- `fir_done`  in  1  filter `done` pulse
- `start_out`  out  1  filter `start`
- `coeff_load_out`  out  1  filter `coeff_load_in`
- `coeff_out`  out  1  filter `coeff_in`
- `load_done`  out  1  one-cycle pulse when a coefficient set has been fully delivered
- `overrun`  out  1  sticky dropped-strobe flag (only with `FIR_COEFF_LOADER_OVERRUN_EN`)

## Operation
- FSM states:
  - `COLLECT`: `wr_ready`=1; each handshake writes `buf[cnt]` and increments `cnt`; accepting the NCoeffs-th coefficient moves to `WAIT`.
  - `WAIT`: `wr_ready`=0; moves to `STREAM` when `busy`=0 and `start_in`=0.
  - `STREAM`: lasts NCoeffs*DataWidth cycles.
  - `GUARD`: 1 cycle, then `COLLECT` with `cnt`=0.
- Bit order:
  - Transmission starts with `buf[NCoeffs-1]` and ends with `buf[0]`; each coefficient is sent MSB first.
  - The first coefficient written therefore lands in filter slot 0, and the first bit sent ends in slot NCoeffs-1 bit DataWidth-1.
- `busy` flag:
  - Set by `start_out`; cleared by `fir_done`.
  - If both occur in the same cycle, `busy` is set.
- Start gating:
  - In `COLLECT` and `WAIT`, `start_out` = `start_in` | `pending`. `start_out` is combinational, zero latency.
  - Issuing `start_out` clears `pending`.
  - In `STREAM` and `GUARD`, `start_out`=0 and `start_in` sets `pending`.
  - If `pending` is already set, a further `start_in` is dropped.
  - A `start_in` in the same cycle that `pending` is issued is also dropped (one start pulse only).
- `GUARD` exists because the filter ignores `start` state-wise while in its coefficient-load state but still shifts samples. No `start_out` is ever issued in the cycle after `coeff_load_out` falls.

## Timing
- Reset values:
  - Outputs: `wr_ready`=0 during reset then 1, `start_out`=0, `coeff_load_out`=0, `coeff_out`=0, `load_done`=0, `overrun`=0.
  - Internal: `buf`=0, `cnt`=0, `busy`=0, `pending`=0, state=`COLLECT`.
- `coeff_load_out` and `coeff_out` are registered.
  - `coeff_load_out` is high for exactly NCoeffs*DataWidth consecutive cycles, starting the cycle after the `WAIT`→`STREAM` decision.
  - `coeff_out` is valid during every cycle `coeff_load_out` is high and 0 otherwise.
- `load_done` pulses in the `GUARD` cycle.
- `wr_ready` returns the cycle after `GUARD`.
- A pending start is issued in the first `COLLECT` cycle.
- Latency from the last write to the first streamed bit, with the filter idle: 2 cycles.
- `wr_valid` while `wr_ready`=0 is ignored. `wr_data` is not captured.
- `rst` mid-stream aborts immediately: outputs drop to reset values the next cycle. The filter must be reset in the same cycle.

## Configuration
- `FIR_COEFF_LOADER_OVERRUN_EN` defined:
  - `overrun` port exists and sets on any dropped `start_in`.
  - It is sticky until `rst`.
- Not defined:
  - Port absent and the flag logic is not compiled.
  - Dropping behaviour is identical.

## Structure
- Shared package `fir_pkg`:
  - State enum `loader_state_e` (`COLLECT`, `WAIT`, `STREAM`, `GUARD`).
  - Helper localparam functions for `NCoeffs` and counter widths (`$clog2(NCoeffs*DataWidth)`), reused by `fir`.
- One natural sub-module: `piso_shifter`, a parallel-load serial-out register of NCoeffs*DataWidth bits, MSB first, with `load`/`shift` controls.
- FSM, `busy`/`pending` tracking and the stream counter stay in the top.

## Test plan
NTaps=9, so NCoeffs=5 and 60 bits per load.
- **Normal load:** write 12'h400, 12'h200, 12'h100, 12'h080, 12'h040 with filter idle.
  - `coeff_load_out` high 60 cycles.
  - First 12 bits = 000001000000, last 12 = 010000000000.
  - `load_done` 1 cycle after the last bit; a `fir` model ends with coeffs[0]=12'h400 and coeffs[4]=12'h040.
- **Busy hold:** `start_in` pulse, then 5 writes before `fir_done`.
  - Loader stays in `WAIT`, `coeff_load_out`=0.
  - Streaming begins 2 cycles after `fir_done`.
- **Start during stream:** `start_in` at stream bit 10.
  - No `start_out` during `STREAM`/`GUARD`.
  - Exactly one `start_out` on the cycle after `GUARD`.
- **Overrun:** two `start_in` during `STREAM`.
  - One `start_out` after `GUARD`; `overrun`=1 (macro on).
  - Identical pulses and no port (macro off).
- **Backpressure:** `wr_valid` held high for 8 cycles with idle filter.
  - Exactly 5 accepted; `wr_ready` low cycles 6–8.
- **Reset mid-stream:** `rst` at bit 30.
  - Next cycle all outputs 0, `wr_ready`=1 after `rst` falls.
  - A fresh 5-write load streams correctly.
